// File: rtl/bus_mux_pkg.sv
// Shared types and helpers for the registered break-before-make bus multiplexer.
package bus_mux_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, TURN} bm_state_t;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned nch);
    return sel < nch;
  endfunction

endpackage

// File: rtl/bus_mux_turnaround_if.sv
// Producer/consumer bundle for bus_mux_turnaround: channel data, select handshake, driven bus.
interface bus_mux_turnaround_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
);
  localparam int unsigned SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [SELW-1:0]      sel;
  logic                 sel_valid;
  logic                 sel_ready;
  logic                 req_off;
  logic [WIDTH-1:0]     out;
  logic                 out_en;
  logic [SELW-1:0]      cur_sel;
  logic                 sel_err;

  modport master (
    output in_data, sel, sel_valid, req_off,
    input  sel_ready, out, out_en, cur_sel, sel_err
  );

  modport slave (
    input  in_data, sel, sel_valid, req_off,
    output sel_ready, out, out_en, cur_sel, sel_err
  );

endinterface

// File: rtl/bus_mux_dead_cnt.sv
// Dead-time down-counter: loads DEAD-1, counts down while enabled, flags zero.
module bus_mux_dead_cnt #(
  parameter int unsigned DEAD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CW = (DEAD > 1) ? $clog2(DEAD) : 1;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(DEAD - 1);
    end else if (dec) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bus_mux_turnaround.sv
// NCH-to-1 registered bus mux; every source change passes through DEAD undriven cycles
// so two producers never appear on the shared bus back to back.
module bus_mux_turnaround
  import bus_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEAD  = 2
) (
  input logic                clk,
  input logic                rst_n,
  bus_mux_turnaround_if.slave bus
);

  bm_state_t        state_q;
  bm_state_t        target_q;
  logic             in_range;
  logic             switching;
  logic             load;
  logic             dec;
  logic             cnt_zero;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] cur_data;

  assign in_range  = sel_in_range(32'(bus.sel), NCH);
  // req_data is only consumed when in_range, so an out-of-range slice is harmless.
  assign req_data  = bus.in_data[32'(bus.sel) * WIDTH +: WIDTH];
  assign cur_data  = bus.in_data[32'(bus.cur_sel) * WIDTH +: WIDTH];
  assign switching = bus.sel_valid && in_range && (bus.sel != bus.cur_sel);

  assign load          = (state_q == DRIVE) && (bus.req_off || switching);
  assign dec           = (state_q == TURN) && !cnt_zero;
  assign bus.sel_ready = (state_q != TURN);

  bus_mux_dead_cnt #(
    .DEAD (DEAD)
  ) u_dead_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .dec   (dec),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= IDLE;
      bus.out     <= '0;
      bus.out_en  <= 1'b0;
      bus.cur_sel <= '0;
      bus.sel_err <= 1'b0;
    end else begin
      bus.sel_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.sel_valid) begin
            if (in_range) begin
              state_q     <= DRIVE;
              bus.cur_sel <= bus.sel;
              bus.out_en  <= 1'b1;
              bus.out     <= req_data;
            end else begin
              bus.sel_err <= 1'b1;
            end
          end
        end
        DRIVE: begin
          // Release beats a simultaneous select; the select is dropped, not queued.
          if (bus.req_off) begin
            state_q    <= TURN;
            target_q   <= IDLE;
            bus.out_en <= 1'b0;
            bus.out    <= '0;
          end else if (switching) begin
            state_q     <= TURN;
            target_q    <= DRIVE;
            bus.cur_sel <= bus.sel;
            bus.out_en  <= 1'b0;
            bus.out     <= '0;
          end else begin
            bus.out <= cur_data;
            if (bus.sel_valid && !in_range) begin
              bus.sel_err <= 1'b1;
            end
          end
        end
        TURN: begin
          if (cnt_zero) begin
            state_q <= target_q;
            if (target_q == DRIVE) begin
              bus.out_en <= 1'b1;
              bus.out    <= cur_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
